// File: rtl/pc_stack.sv
// Program counter with a hardware return-address stack.
// One operation per cycle: ret > call > load > branch > enable > hold.
module pc_stack #(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       load,
    input  logic [WIDTH-1:0]           load_addr,
    input  logic                       branch,
    input  logic [WIDTH-1:0]           offset,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       err_clr,
    output logic [WIDTH-1:0]           pc_out,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf_err,
    output logic                       unf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] stack [DEPTH];
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc_inc;
    logic [LW-1:0]    level_next;
    logic [LW-1:0]    level_dec;
    logic             push;
    logic             set_ovf;
    logic             set_unf;

    assign empty     = (level == '0);
    assign full      = (level == LW'(DEPTH));
    assign pc_inc    = pc_out + WIDTH'(1);
    assign level_dec = level - LW'(1);

    always_comb begin
        pc_next    = pc_out;
        level_next = level;
        push       = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        if (ret) begin
            if (empty) begin
                set_unf = 1'b1;
            end else begin
                pc_next    = stack[level_dec[AW-1:0]];
                level_next = level_dec;
            end
        end else if (call) begin
            if (full) begin
                set_ovf = 1'b1;
            end else begin
                push       = 1'b1;
                pc_next    = load_addr;
                level_next = level + LW'(1);
            end
        end else if (load) begin
            pc_next = load_addr;
        end else if (branch) begin
            pc_next = pc_out + offset;
        end else if (enable) begin
            pc_next = pc_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out  <= RESET_VEC;
            level   <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            pc_out  <= pc_next;
            level   <= level_next;
            // a flag being set in the same cycle beats err_clr
            ovf_err <= set_ovf | (ovf_err & ~err_clr);
            unf_err <= set_unf | (unf_err & ~err_clr);
        end
    end

    // entry storage carries no reset; level alone says what is valid
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            stack[level[AW-1:0]] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_stack.sv
// Directed self-checking bench for pc_stack (WIDTH=16, DEPTH=8).
module tb_pc_stack;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, load, branch, call, ret, err_clr;
    logic [15:0] load_addr, offset;
    logic [15:0] pc_out;
    logic [3:0]  level;
    logic        empty, full, ovf_err, unf_err;

    int tests = 0;
    int fails = 0;

    pc_stack #(.WIDTH(16), .DEPTH(8), .RESET_VEC(16'h0000)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .load_addr(load_addr), .branch(branch), .offset(offset),
        .call(call), .ret(ret), .err_clr(err_clr), .pc_out(pc_out),
        .level(level), .empty(empty), .full(full),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        enable = 0; load = 0; branch = 0; call = 0; ret = 0; err_clr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_pc;
        idle();
        load_addr = '0;
        offset = '0;
        rst = 1;
        #3;
        check("rst_pc", 32'(pc_out), 0);
        check("rst_level", 32'(level), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_flags", {30'd0, ovf_err, unf_err}, 0);

        @(negedge clk);
        rst = 0;
        enable = 1;
        step(); check("en1", 32'(pc_out), 32'h0001);
        step(); check("en2", 32'(pc_out), 32'h0002);
        step(); check("en3", 32'(pc_out), 32'h0003);

        idle(); load = 1; load_addr = 16'hFFFF;
        step(); check("load_ffff", 32'(pc_out), 32'hFFFF);
        idle(); enable = 1;
        step(); check("wrap", 32'(pc_out), 32'h0000);
        check("wrap_flags", {30'd0, ovf_err, unf_err}, 0);

        idle(); load = 1; load_addr = 16'h0100;
        step(); check("load_100", 32'(pc_out), 32'h0100);
        idle(); branch = 1; enable = 1; offset = 16'hFFF0;
        step(); check("branch_en", 32'(pc_out), 32'h00F0);
        idle(); branch = 1; load = 1; load_addr = 16'h0010;
        offset = 16'h0004;
        step(); check("load_over_branch", 32'(pc_out), 32'h0010);

        idle(); call = 1; load_addr = 16'h2000;
        step(); check("call_pc", 32'(pc_out), 32'h2000);
        check("call_level", 32'(level), 1);
        check("call_empty", 32'(empty), 0);
        idle(); ret = 1;
        step(); check("ret_pc", 32'(pc_out), 32'h0011);
        check("ret_level", 32'(level), 0);
        check("ret_empty", 32'(empty), 1);

        // nested calls: push 0012, 1001, 1101, ... 1601
        for (int i = 0; i < 8; i++) begin
            idle(); call = 1; load_addr = 16'h1000 + 16'(i) * 16'h0100;
            step();
            check("nest_level", 32'(level), 32'(i + 1));
        end
        check("nest_pc", 32'(pc_out), 32'h1700);
        check("nest_full", 32'(full), 1);
        idle(); call = 1; load_addr = 16'h3000;
        step(); check("ovf_pc", 32'(pc_out), 32'h1700);
        check("ovf_level", 32'(level), 8);
        check("ovf_flag", 32'(ovf_err), 1);

        for (int k = 7; k >= 0; k--) begin
            idle(); ret = 1;
            if (k == 7) call = 1;
            exp_pc = (k == 0) ? 16'h0012 : 16'h0F01 + 16'(k) * 16'h0100;
            step();
            check("pop_pc", 32'(pc_out), 32'(exp_pc));
            check("pop_level", 32'(level), 32'(k));
        end
        check("pop_empty", 32'(empty), 1);
        check("ovf_sticky", 32'(ovf_err), 1);

        idle(); err_clr = 1;
        step(); check("ovf_clr", 32'(ovf_err), 0);
        idle(); ret = 1;
        step(); check("unf_flag", 32'(unf_err), 1);
        check("unf_pc", 32'(pc_out), 32'h0012);
        idle(); err_clr = 1;
        step(); check("unf_clr", 32'(unf_err), 0);
        idle(); err_clr = 1; ret = 1;
        step(); check("unf_set_wins", 32'(unf_err), 1);

        idle(); load = 1; load_addr = 16'h0050;
        step(); check("pre_rst_pc", 32'(pc_out), 32'h0050);
        idle(); call = 1; load_addr = 16'h4000;
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        check("async_pc", 32'(pc_out), 0);
        check("async_level", 32'(level), 0);
        check("async_flags", {30'd0, ovf_err, unf_err}, 0);
        @(negedge clk);
        rst = 0;
        idle();
        step(); check("post_rst_level", 32'(level), 0);
        check("post_rst_pc", 32'(pc_out), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter WIDTH, default 16, program-counter and address width in bits (>= 4).
REQ-002 Parameter DEPTH, default 8, return-stack entries (power of two, >= 2).
REQ-003 Parameter RESET_VEC, default 0, PC value after reset (WIDTH bits).
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port enable  input  1  increment PC by 1 this cycle.
REQ-007 Port load  input  1  load PC from load_addr.
REQ-008 Port load_addr  input  WIDTH  absolute load target.
REQ-009 Port branch  input  1  relative jump: PC + offset.
REQ-010 Port offset  input  WIDTH  two's-complement branch displacement.
REQ-011 Port call  input  1  push return address, jump to load_addr.
REQ-012 Port ret  input  1  pop return address into PC.
REQ-013 Port err_clr  input  1  clear sticky error flags.
REQ-014 Port pc_out  output  WIDTH  current PC, registered.
REQ-015 Port level  output  $clog2(DEPTH)+1  occupied stack entries, 0..DEPTH.
REQ-016 Port empty  output  1  level == 0.
REQ-017 Port full  output  1  level == DEPTH.
REQ-018 Port ovf_err  output  1  sticky: call attempted while full.
REQ-019 Port unf_err  output  1  sticky: ret attempted while empty.

Function
REQ-020 Exactly one operation per cycle, fixed priority: ret > call > load > branch > enable > hold.
REQ-021 Lower-priority requests asserted together with a higher one are ignored, not queued.
REQ-022 enable: pc_out <= pc_out + 1, modulo 2^WIDTH (all-ones wraps to 0, no flag).
REQ-023 load: pc_out <= load_addr next edge.
REQ-024 branch: pc_out <= pc_out + offset, modulo 2^WIDTH; offset all-ones steps back by 1.
REQ-025 call when not full: stack[level] <= pc_out + 1 (modulo 2^WIDTH); level <= level + 1; pc_out <= load_addr; all same edge.
REQ-026 call when full: no push, PC holds, level holds, ovf_err <= 1.
REQ-027 ret when not empty: pc_out <= stack[level-1]; level <= level - 1.
REQ-028 ret when empty: PC holds, level holds, unf_err <= 1.
REQ-029 Stack is LIFO; popped entry contents are don't-care afterwards; no read of stale entries reaches pc_out.
REQ-030 Latency: every operation visible on pc_out/level/flags one clock after the sampling edge; no combinational input-to-output path.
REQ-031 empty and full derived from the registered level only.
REQ-032 err_clr clears both flags next edge; if the same cycle sets a flag, set wins.
REQ-033 Flags have no effect on operation; a failed call/ret consumes its cycle as a hold.

Reset
REQ-034 rst asserted: immediately, without clk, pc_out = RESET_VEC, level = 0, empty = 1, full = 0, ovf_err = 0, unf_err = 0.
REQ-035 Stack entry storage is not reset.
REQ-036 While rst is high all requests are ignored; first operation is taken at the first rising edge after deassertion.
REQ-037 rst mid-call or mid-ret discards the operation completely; no partial push/pop.

Verification
REQ-038 Reset then enable for 3 cycles, WIDTH=16 -> pc_out 0x0000,0x0001,0x0002,0x0003; load 0xFFFF then enable -> 0x0000, no flag.
REQ-039 pc_out=0x0100, branch offset=0xFFF0 -> 0x00F0; same cycle with enable also high -> branch result only.
REQ-040 pc_out=0x0010, call load_addr=0x2000 -> pc_out 0x2000, level 1; ret -> pc_out 0x0011, level 0, empty=1.
REQ-041 DEPTH=8: 8 nested calls -> full=1, level 8; 9th call -> ovf_err=1, pc_out and level unchanged; 8 rets return addresses in reverse order.
REQ-042 ret while empty -> unf_err=1, PC held; err_clr -> flag 0; err_clr with simultaneous failing ret -> flag stays 1.
REQ-043 Assert rst asynchronously between edges during a cycle with call high -> outputs to reset values before next edge; level 0 after release.
